// File: rtl/pc_stack_unit.sv
// Program-counter stage: sequences the next fetch address (next/jump/call/return)
// and keeps a small LIFO of return addresses with sticky overflow/underflow flags.
module pc_stack_unit #(
    parameter int                ADDR_W     = 8,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}}
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       EN,
    input  logic [1:0]                 COND,
    input  logic [ADDR_W-1:0]          TARGET,
    output logic [ADDR_W-1:0]          PC,
    output logic [$clog2(DEPTH):0]     SP,
    output logic                       STACK_OVF,
    output logic                       STACK_UNF
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [SP_W-1:0]   SP_ONE  = {{(SP_W-1){1'b0}}, 1'b1};
    localparam logic [SP_W-1:0]   SP_ZERO = {SP_W{1'b0}};
    localparam logic [SP_W-1:0]   SP_FULL = SP_W'(DEPTH);

    localparam logic [1:0] COND_NEXT = 2'b00;
    localparam logic [1:0] COND_JUMP = 2'b01;
    localparam logic [1:0] COND_CALL = 2'b10;
    localparam logic [1:0] COND_RET  = 2'b11;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [DEPTH];

    logic [ADDR_W-1:0] pc_inc_s;
    logic [SP_W-1:0]   sp_inc_s;
    logic [SP_W-1:0]   sp_dec_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic              push_s;

    // Address/pointer arithmetic shared by the next-state logic
    always_comb begin
        pc_inc_s = pc_q + PC_ONE;
        sp_inc_s = sp_q + SP_ONE;
        sp_dec_s = sp_q - SP_ONE;
        wr_idx_s = sp_q[IDX_W-1:0];
        rd_idx_s = sp_dec_s[IDX_W-1:0];
    end

    // Next-state selection; a failed call/return degrades to a plain increment
    always_comb begin
        pc_d   = pc_q;
        sp_d   = sp_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        push_s = 1'b0;
        if (EN) begin
            case (COND)
                COND_NEXT: pc_d = pc_inc_s;
                COND_JUMP: pc_d = TARGET;
                COND_CALL: begin
                    if (sp_q != SP_FULL) begin
                        push_s = 1'b1;
                        sp_d   = sp_inc_s;
                        pc_d   = TARGET;
                    end else begin
                        pc_d  = pc_inc_s;
                        ovf_d = 1'b1;
                    end
                end
                COND_RET: begin
                    if (sp_q != SP_ZERO) begin
                        pc_d = stack_q[rd_idx_s];
                        sp_d = sp_dec_s;
                    end else begin
                        pc_d  = pc_inc_s;
                        unf_d = 1'b1;
                    end
                end
                default: pc_d = pc_q;
            endcase
        end else begin
            pc_d = pc_q;
        end
    end

    // Architectural state with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q  <= RESET_ADDR;
            sp_q  <= SP_ZERO;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Return-address storage; contents are don't-care until pushed
    always_ff @(posedge CLK) begin
        if (!RST && push_s) begin
            stack_q[wr_idx_s] <= pc_inc_s;
        end
    end

    assign PC        = pc_q;
    assign SP        = sp_q;
    assign STACK_OVF = ovf_q;
    assign STACK_UNF = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the program counter and call stack.
module tb_pc_stack_unit;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b0;
    logic [1:0] COND = 2'b00;
    logic [7:0] TARGET = 8'h00;
    logic [7:0] PC;
    logic [2:0] SP;
    logic       STACK_OVF;
    logic       STACK_UNF;

    int checks = 0;
    int errors = 0;

    // reference model
    int m_pc = 0;
    int m_stack[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    logic [12:0] obs_s;
    logic [12:0] exp_v;
    assign obs_s = {PC, SP, STACK_OVF, STACK_UNF};

    pc_stack_unit #(.ADDR_W(8), .DEPTH(4), .RESET_ADDR(8'h00)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .COND(COND), .TARGET(TARGET),
        .PC(PC), .SP(SP), .STACK_OVF(STACK_OVF), .STACK_UNF(STACK_UNF)
    );

    always #5 CLK = ~CLK;

    function automatic logic [12:0] model_vec();
        logic [7:0] p;
        logic [2:0] s;
        p = m_pc[7:0];
        s = 3'(m_stack.size());
        return {p, s, m_ovf, m_unf};
    endfunction

    // one clock: drive, advance model by the instruction-level rules, settle
    task automatic step(input logic rst, input logic en, input logic [1:0] cond, input logic [7:0] tgt);
        RST = rst; EN = en; COND = cond; TARGET = tgt;
        @(posedge CLK);
        if (rst) begin
            m_pc = 0; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (en) begin
            if (cond == 2'b00) m_pc = (m_pc + 1) % 256;
            else if (cond == 2'b01) m_pc = tgt;
            else if (cond == 2'b10) begin
                if (m_stack.size() < 4) begin
                    m_stack.push_back((m_pc + 1) % 256);
                    m_pc = tgt;
                end else begin
                    m_pc = (m_pc + 1) % 256;
                    m_ovf = 1'b1;
                end
            end else begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin
                    m_pc = (m_pc + 1) % 256;
                    m_unf = 1'b1;
                end
            end
        end
        #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 2'b00, 8'h00);
        exp_v = {8'h00, 3'd0, 2'b00};
        checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL reset: observed %h required %h", obs_s, exp_v); end
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b1, 2'b00, 8'hAA);
            exp_v = {8'(i), 3'd0, 2'b00};
            checks++;
            if (obs_s !== exp_v) begin errors++; $display("FAIL next_%0d: observed %h required %h", i, obs_s, exp_v); end
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 2'b01, 8'hFF);
        step(1'b0, 1'b1, 2'b00, 8'h12);
        exp_v = {8'h00, 3'd0, 2'b00};
        checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL wrap: observed %h required %h", obs_s, exp_v); end
    endtask

    task automatic test_jump_hold();
        step(1'b0, 1'b1, 2'b01, 8'h10);
        step(1'b0, 1'b1, 2'b01, 8'h40);
        exp_v = {8'h40, 3'd0, 2'b00};
        checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL jump: observed %h required %h", obs_s, exp_v); end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 2'b01, 8'h99);
            checks++;
            if (obs_s !== exp_v) begin errors++; $display("FAIL hold_%0d: observed %h required %h", i, obs_s, exp_v); end
        end
    endtask

    task automatic test_call_return();
        step(1'b0, 1'b1, 2'b01, 8'h05);
        step(1'b0, 1'b1, 2'b10, 8'h20);
        step(1'b0, 1'b1, 2'b10, 8'h30);
        exp_v = {8'h30, 3'd2, 2'b00};
        checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL call2: observed %h required %h", obs_s, exp_v); end
        step(1'b0, 1'b1, 2'b11, 8'hEE);
        exp_v = {8'h21, 3'd1, 2'b00};
        checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL ret1: observed %h required %h", obs_s, exp_v); end
        step(1'b0, 1'b1, 2'b11, 8'hEE);
        exp_v = {8'h06, 3'd0, 2'b00};
        checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL ret2: observed %h required %h", obs_s, exp_v); end
    endtask

    task automatic test_overflow();
        logic [7:0] rets [4];
        rets[0] = 8'h51; rets[1] = 8'h34; rets[2] = 8'h23; rets[3] = 8'h12;
        step(1'b1, 1'b0, 2'b00, 8'h00);
        step(1'b0, 1'b1, 2'b10, 8'h11);
        step(1'b0, 1'b1, 2'b10, 8'h22);
        step(1'b0, 1'b1, 2'b10, 8'h33);
        step(1'b0, 1'b1, 2'b10, 8'h50);
        step(1'b0, 1'b1, 2'b10, 8'h77);
        exp_v = {8'h51, 3'd4, 2'b10};
        checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL ovf_call: observed %h required %h", obs_s, exp_v); end
        // after the first return we land on 0x34; the remaining entries follow
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 2'b11, 8'h00);
            exp_v = {(i == 3) ? 8'h01 : rets[i+1 > 3 ? 3 : i+1], 3'(3 - i), 2'b10};
            checks++;
            if (obs_s !== exp_v) begin errors++; $display("FAIL ovf_unwind_%0d: observed %h required %h", i, obs_s, exp_v); end
        end
    endtask

    task automatic test_underflow();
        step(1'b1, 1'b0, 2'b00, 8'h00);
        step(1'b0, 1'b1, 2'b01, 8'h07);
        step(1'b0, 1'b1, 2'b11, 8'h44);
        exp_v = {8'h08, 3'd0, 2'b01};
        checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL unf: observed %h required %h", obs_s, exp_v); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 2'b00, 8'h00);
            exp_v = {8'(9 + i), 3'd0, 2'b01};
            checks++;
            if (obs_s !== exp_v) begin errors++; $display("FAIL unf_sticky_%0d: observed %h required %h", i, obs_s, exp_v); end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 2'b00, 8'h00);
        step(1'b0, 1'b1, 2'b11, 8'h00);
        step(1'b0, 1'b1, 2'b10, 8'h60);
        step(1'b0, 1'b1, 2'b10, 8'h70);
        step(1'b0, 1'b1, 2'b10, 8'h80);
        exp_v = {8'h80, 3'd3, 2'b01};
        checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL pre_rst: observed %h required %h", obs_s, exp_v); end
        step(1'b1, 1'b1, 2'b10, 8'h90);
        exp_v = {8'h00, 3'd0, 2'b00};
        checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL rst_mid: observed %h required %h", obs_s, exp_v); end
        step(1'b0, 1'b1, 2'b11, 8'h00);
        exp_v = {8'h01, 3'd0, 2'b01};
        checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL rst_empty_ret: observed %h required %h", obs_s, exp_v); end
    endtask

    task automatic test_random();
        logic       r, e;
        logic [1:0] c;
        logic [7:0] t;
        step(1'b1, 1'b0, 2'b00, 8'h00);
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 4) != 0);
            c = 2'($urandom_range(0, 3));
            t = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) t = PC;
            step(r, e, c, t);
            exp_v = model_vec();
            checks++;
            if (obs_s !== exp_v) begin errors++; $display("FAIL random_%0d: observed %h required %h", i, obs_s, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_jump_hold();
        test_call_return();
        test_overflow();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
